sgd_server_round_sched: RTL
===========================

# sgd_server_round_sched

Round scheduler for the parameter-server receive path. It counts the gradient beats each worker writes into its per-engine receive buffers. When every active worker holds at least one complete chunk (ENGINE_NUM beats), it pops one chunk from all active workers at the same time, so the aggregation stage always sees a coherent round. It also enforces a configurable spacing between rounds, flags straggler workers on timeout, and reports round and overflow status.

## Interface
Parameters:
- WORKER_NUM, 4: number of workers (buffer groups).
- ENGINE_NUM, 8: beats per chunk, one per engine FIFO of a worker.
- CNT_W, 6: width of the per-worker chunk counter; saturates at 2^CNT_W-1.
- TO_W, 24: width of the timeout counter and `cfg_timeout`.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_enable  in  1  scheduler run enable.
- cfg_worker_mask  in  WORKER_NUM  active workers. Change only while `busy`=0.
- cfg_gap  in  4  idle cycles after each release.
- cfg_timeout  in  TO_W  straggler timeout in cycles; 0 disables the timeout.
- beat_wr  in  WORKER_NUM  one-cycle pulse per beat written into worker m's buffers.
- rd_en  out  WORKER_NUM  pop one beat from every engine FIFO of worker m.
- round_done  out  1  one-cycle pulse per released round.
- round_cnt  out  32  number of rounds released; wraps.
- straggler  out  WORKER_NUM  sticky; worker m missed a timeout. Cleared by `rst` only.
- timeout_pulse  out  1  one-cycle pulse per expired timeout.
- err_ovf  out  1  sticky; a chunk counter saturated and dropped a completed chunk.
- busy  out  1  high while state ≠ IDLE.

## Operation
Per-worker beat counting:
- Each worker m has `beat_idx[m]` (0..ENGINE_NUM-1) and `chunk_cnt[m]` (CNT_W bits).
- On `beat_wr[m]`, `beat_idx[m]` increments. When it wraps from ENGINE_NUM-1 to 0, `chunk_cnt[m]` increments.
- For a worker with its mask bit 0, `beat_wr` is ignored and both counters are held at 0.
- Counting also runs while in IDLE.
- Chunk completion and a release on the same cycle leave `chunk_cnt` unchanged (net +1-1).
- If `chunk_cnt[m]` is at its maximum and another chunk completes with no release that cycle, the count stays at max and `err_ovf` is set.

Round readiness:
- `ready_m` = `chunk_cnt[m]` ≠ 0.
- `all_ready` = mask ≠ 0 and every masked worker has `ready_m`.

State machine:
- IDLE: go to WAIT_ALL when `cfg_enable`=1.
- WAIT_ALL:
  - If `cfg_enable`=0, go to IDLE.
  - Else if `all_ready`, go to RELEASE.
  - Otherwise run the timeout logic and stay.
- RELEASE (exactly 1 cycle):
  - `rd_en` = mask, `round_done`=1.
  - `round_cnt` increments, each masked `chunk_cnt` decrements, the timeout counter clears.
  - Next state is GAP if `cfg_gap`≠0, else WAIT_ALL.
  - This cycle completes even if `cfg_enable` has dropped.
- GAP:
  - Stays for `cfg_gap` cycles, then goes to WAIT_ALL.
  - `cfg_enable`=0 goes to IDLE immediately.

Timeout logic:
- Active only in WAIT_ALL with `cfg_timeout`≠0.
- The timeout counter increments each cycle in which at least one masked worker is ready and `all_ready`=0. Otherwise it holds at 0.
- When it reaches `cfg_timeout`:
  - `timeout_pulse`=1 for one cycle.
  - `straggler` |= mask & ~ready.
  - The counter clears and waiting continues.

## Timing
Reset values:
- `rd_en`=0, `round_done`=0, `round_cnt`=0, `straggler`=0, `timeout_pulse`=0, `err_ovf`=0, `busy`=0.
- State IDLE; all `beat_idx`, `chunk_cnt` and the timeout counter are 0.

Cycle behaviour:
- All outputs are registered; `rd_en`/`round_done` are high exactly during the RELEASE cycle.
- Latency: last needed `beat_wr` at cycle t → `chunk_cnt` updated at t+1 → RELEASE (`rd_en` high) at t+2.
- Round spacing is at least `cfg_gap`+2 cycles (RELEASE, GAP×`cfg_gap`, ≥1 WAIT_ALL).
- The FIFO read data is valid one cycle after `rd_en`; consumers handle that.

Reset mid-operation:
- `rst` in any state returns the block to reset values on the next edge.
- Partially counted beats are discarded. The owner also resets the FIFOs.

## Test plan
- Setup: WORKER_NUM=4, ENGINE_NUM=8, mask=4'b1111, gap=0. Stimulus: 8 beats to each worker, all ending at cycle 20 → `rd_en`=4'hF at cycle 22 only, `round_done` one pulse, `round_cnt`=1, all `chunk_cnt`=0.
- Setup: mask=4'b0101. Stimulus: worker 0 receives 16 beats, worker 2 receives 8 beats, workers 1 and 3 receive beats throughout → exactly one release with `rd_en`=4'b0101, worker 0 `chunk_cnt`=1 afterwards, workers 1 and 3 counters stay 0.
- Setup: gap=3. Stimulus: 3 chunks preloaded on all workers → releases 5 cycles apart, `round_cnt`=3.
- Setup: timeout=100. Stimulus: workers 0–2 ready, worker 3 silent → `timeout_pulse` at the 100th waiting cycle, `straggler`=4'b1000, repeats every 100 cycles. Worker 3 then sends 8 beats → release 2 cycles after its last beat; `straggler` stays set.
- Setup: CNT_W=2. Stimulus: worker 1 receives 4 chunks with no release (worker 0 silent) → `chunk_cnt[1]`=3 and `err_ovf`=1.
- Stimulus: `cfg_enable` dropped during GAP, then `rst` pulsed during WAIT_ALL with partial beats counted → IDLE next cycle; after reset all outputs and counters are 0, and a fresh 8-beat round releases normally.

Source files
------------

// File: rtl/sgd_server_round_sched.sv
// Round scheduler for the parameter-server receive path: counts per-worker
// gradient beats and pops one chunk from every active worker at once.
module sgd_server_round_sched #(
  parameter int WORKER_NUM = 4,
  parameter int ENGINE_NUM = 8,
  parameter int CNT_W      = 6,
  parameter int TO_W       = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic [WORKER_NUM-1:0] cfg_worker_mask,
  input  logic [3:0]            cfg_gap,
  input  logic [TO_W-1:0]       cfg_timeout,
  input  logic [WORKER_NUM-1:0] beat_wr,
  output logic [WORKER_NUM-1:0] rd_en,
  output logic                  round_done,
  output logic [31:0]           round_cnt,
  output logic [WORKER_NUM-1:0] straggler,
  output logic                  timeout_pulse,
  output logic                  err_ovf,
  output logic                  busy
);

  localparam int IDX_W = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENGINE_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, WAIT_ALL, RELEASE, GAP} state_t;

  state_t                           state;
  logic [WORKER_NUM-1:0][IDX_W-1:0] beat_idx;
  logic [WORKER_NUM-1:0][CNT_W-1:0] chunk_cnt;
  logic [WORKER_NUM-1:0]            ready;
  logic [WORKER_NUM-1:0]            chunk_done;
  logic                             all_ready;
  logic                             any_ready;
  logic                             rel;
  logic [3:0]                       gap_cnt;
  logic [TO_W-1:0]                  to_cnt;
  logic [TO_W-1:0]                  to_inc;

  always_comb begin
    ready      = '0;
    chunk_done = '0;
    for (int m = 0; m < WORKER_NUM; m++) begin
      ready[m]      = (chunk_cnt[m] != '0);
      chunk_done[m] = beat_wr[m] && (beat_idx[m] == IDX_LAST);
    end
  end

  assign all_ready = (cfg_worker_mask != '0) &&
                     ((ready & cfg_worker_mask) == cfg_worker_mask);
  assign any_ready = |(ready & cfg_worker_mask);
  assign rel       = (state == RELEASE);
  assign to_inc    = to_cnt + TO_W'(1);

  // Per-worker beat/chunk counting; a completion and a release on the same
  // cycle cancel, a completion at saturation is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx  <= '0;
      chunk_cnt <= '0;
      err_ovf   <= 1'b0;
    end else begin
      for (int m = 0; m < WORKER_NUM; m++) begin
        if (!cfg_worker_mask[m]) begin
          beat_idx[m]  <= '0;
          chunk_cnt[m] <= '0;
        end else begin
          if (beat_wr[m])
            beat_idx[m] <= (beat_idx[m] == IDX_LAST) ? '0 : beat_idx[m] + 1'b1;
          if (chunk_done[m] && !rel) begin
            if (chunk_cnt[m] == CNT_MAX) err_ovf <= 1'b1;
            else                         chunk_cnt[m] <= chunk_cnt[m] + 1'b1;
          end else if (!chunk_done[m] && rel) begin
            chunk_cnt[m] <= chunk_cnt[m] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_en         <= '0;
      round_done    <= 1'b0;
      round_cnt     <= '0;
      straggler     <= '0;
      timeout_pulse <= 1'b0;
      busy          <= 1'b0;
      gap_cnt       <= '0;
      to_cnt        <= '0;
    end else begin
      rd_en         <= '0;
      round_done    <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_enable) begin
            state <= WAIT_ALL;
            busy  <= 1'b1;
          end
        end
        WAIT_ALL: begin
          if (!cfg_enable) begin
            state  <= IDLE;
            busy   <= 1'b0;
            to_cnt <= '0;
          end else if (all_ready) begin
            state      <= RELEASE;
            rd_en      <= cfg_worker_mask;
            round_done <= 1'b1;
            to_cnt     <= '0;
          end else if ((cfg_timeout != '0) && any_ready) begin
            // Someone is ready but not everyone: a straggler is holding the round.
            if (to_inc == cfg_timeout) begin
              timeout_pulse <= 1'b1;
              straggler     <= straggler | (cfg_worker_mask & ~ready);
              to_cnt        <= '0;
            end else begin
              to_cnt <= to_inc;
            end
          end else begin
            to_cnt <= '0;
          end
        end
        RELEASE: begin
          round_cnt <= round_cnt + 32'd1;
          to_cnt    <= '0;
          if (cfg_gap != 4'd0) begin
            state   <= GAP;
            gap_cnt <= cfg_gap - 4'd1;
          end else begin
            state <= WAIT_ALL;
          end
        end
        GAP: begin
          if (!cfg_enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt == 4'd0) begin
            state <= WAIT_ALL;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
